imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (IF) and the memory stage (DM) of the 5-stage pipeline.
- Arbitrates between the two, sequences one outstanding transaction at a time, and routes responses back to the requester.
- Produces fetch and memory stall requests, which the pipeline hazard logic ORs into its existing stall/flush network.
- DM has fixed priority; a starvation counter guarantees IF eventual service.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; must be a multiple of 8.
- MAX_IF_WAIT, 4, number of consecutive lost arbitrations after which IF wins the next one (range 1..15).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request, level; held until if_rvalid_o
- if_addr_i  in  AW  fetch address
- if_kill_i  in  1  branch/jump flush; discard any in-flight fetch
- if_rvalid_o  out  1  fetch data valid, one-cycle pulse
- if_rdata_o  out  DW  fetch data
- dm_req_i  in  1  data request, level; held until dm_rvalid_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_be_i  in  DW/8  byte enables
- dm_addr_i  in  AW  data address
- dm_wdata_i  in  DW  store data
- dm_rvalid_o  out  1  load data valid / store acknowledge, one-cycle pulse
- dm_rdata_o  out  DW  load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DW/8  memory byte enables
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_gnt_i  in  1  memory accepted request this cycle
- mem_rvalid_i  in  1  memory response valid (read data or write ack)
- mem_rdata_i  in  DW  memory read data
- stall_f_o  out  1  fetch stage must hold
- stall_m_o  out  1  memory stage must hold

Behaviour:
- FSM states: IDLE, REQ, RESP. Owner register: OWN_IF / OWN_DM. Kill flag: kill_q.
- Reset state: IDLE, owner OWN_DM, kill_q=0, starvation count=0, all mem_* outputs 0.
- rdata outputs are don't-care under reset.
- IDLE, arbitration:
  - If only one requester, it wins.
  - If both request, DM wins unless the starvation count equals MAX_IF_WAIT, in which case IF wins.
  - The winner's address, we, be and wdata are captured into registers; next state is REQ.
  - IF requests are captured with we=0 and be all-ones.
- REQ:
  - mem_* outputs are driven from the registers; mem_req_o=1.
  - Hold until mem_gnt_i=1, then go to RESP with mem_req_o=0 in the next cycle.
- RESP:
  - Wait for mem_rvalid_i.
  - In the same cycle, combinationally pulse the owner's rvalid_o, route mem_rdata_i to the owner's rdata_o, and go to IDLE.
  - New arbitration happens in the following cycle; there is no back-to-back issue.
- Minimum latency: request seen at cycle N, mem_req_o at N+1, rvalid_o at N+2 when mem_gnt_i=1 at N+1 and mem_rvalid_i=1 at N+2.
- Starvation counter (4 bits):
  - Increments in every IDLE cycle where DM wins while if_req_i=1.
  - Cleared when IF wins, or in any cycle with if_req_i=0.
  - Saturates at MAX_IF_WAIT.
- if_kill_i:
  - While owner=OWN_IF and the state is REQ or RESP, sets kill_q.
  - The matching response is consumed and if_rvalid_o is suppressed.
  - The transaction is not aborted at the memory, because the request is already committed.
  - kill_q clears on return to IDLE.
  - if_kill_i in IDLE has no effect: the pipeline presents the new PC as if_addr_i.
  - An if_kill_i arriving in the same cycle as mem_rvalid_i suppresses that pulse.
- Stalls:
  - stall_f_o = if_req_i & ~if_rvalid_o.
  - stall_m_o = dm_req_i & ~dm_rvalid_o.
  - Both are combinational and asserted in every waiting cycle, including lost-arbitration cycles.
- mem_rvalid_i in IDLE or REQ is ignored; this covers stale responses after a reset.
- Reset asserted mid-transaction returns the block to IDLE immediately, with no rvalid pulse.
- Requesters must not change addr/data while their req is high; the arbiter samples only in IDLE.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, REQ, RESP};
  - typedef enum owner_t {OWN_IF, OWN_DM};
  - localparam default widths.
- One natural sub-module: arb_starve_cnt, the saturating starvation counter with its win-override output. All other logic sits in the top module.

Test Plan:
- Lone fetch: if_req_i=1, addr 0x100; memory grants at once and returns 0xDEADBEEF one cycle later. Expect mem_req_o at N+1, if_rvalid_o pulse at N+2 with data 0xDEADBEEF, stall_f_o high at N and N+1 and low at N+2.
- Simultaneous requests: if_req_i=dm_req_i=1, dm load at 0x2000. Expect DM served first (mem_addr_o=0x2000, mem_we_o=0), then IF served; stall_f_o high throughout the DM transaction.
- Starvation, MAX_IF_WAIT=2: IF held high while DM issues continuous requests. Expect DM to win 2 arbitrations and IF to win the 3rd, with the counter then cleared.
- Kill in flight: IF transaction to 0x100 in RESP; pulse if_kill_i, then mem_rvalid_i=1. Expect no if_rvalid_o pulse, state back to IDLE, next fetch at the new address served normally.
- Store with stalled memory: dm_we_i=1, be=0b0011, wdata 0x1234ABCD; mem_gnt_i low for 3 cycles. Expect mem_req_o and all payload fields stable for 4 cycles, then dm_rvalid_o on the ack and stall_m_o deasserted in that cycle.
- Reset mid-op: assert rst_i during RESP, then drive mem_rvalid_i after reset. Expect all outputs 0, state IDLE, and no rvalid pulse on either port.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the IF/DM unified-memory arbiter.
//   arb_state_t : sequencer states (IDLE -> REQ -> RESP -> IDLE)
//   owner_t     : which requester owns the in-flight transaction
package mem_arb_pkg;

  localparam int unsigned AW_DEF          = 32;
  localparam int unsigned DW_DEF          = 32;
  localparam int unsigned MAX_IF_WAIT_DEF = 4;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter for the fetch port.
//   clk_i, rst_i : clock, synchronous active-high reset
//   if_req_i     : fetch request level; clears the count when low
//   dm_win_i     : DM won an arbitration while IF was also requesting
//   if_win_i     : IF won an arbitration; clears the count
//   if_force_o   : count has reached MAX_IF_WAIT, IF wins the next arbitration
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_IF_WAIT = MAX_IF_WAIT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic dm_win_i,
  input  logic if_win_i,
  output logic if_force_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_IF_WAIT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on IF win or idle fetch port, otherwise count lost arbitrations up to the limit
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req_i || if_win_i) begin
      cnt_d = CNT_ZERO;
    end else if (dm_win_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign if_force_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-ported unified memory between the fetch (IF)
// and memory (DM) stages. One transaction in flight at a time; DM has fixed
// priority except when the starvation counter forces an IF win.
//   if_*   : fetch port (read-only), level request held until if_rvalid_o
//   dm_*   : data port (load/store), level request held until dm_rvalid_o
//   mem_*  : memory port; request/grant handshake then a single response
//   stall_f_o / stall_m_o : hold requests for the pipeline hazard logic
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned MAX_IF_WAIT = MAX_IF_WAIT_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  input  logic            if_kill_i,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [DW/8-1:0] dm_be_i,
  input  logic [AW-1:0]   dm_addr_i,
  input  logic [DW-1:0]   dm_wdata_i,
  output logic            dm_rvalid_o,
  output logic [DW-1:0]   dm_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            stall_f_o,
  output logic            stall_m_o
);

  localparam int unsigned BW = DW / 8;

  arb_state_t      state_q;
  owner_t          owner_q;
  logic            kill_q;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [BW-1:0]   be_q;
  logic [DW-1:0]   wdata_q;

  logic            if_force_s;
  logic            in_idle_s;
  logic            if_win_s;
  logic            dm_win_s;
  logic            resp_done_s;

  assign in_idle_s = (state_q == IDLE);
  // DM has priority unless IF has lost MAX_IF_WAIT arbitrations in a row
  assign if_win_s  = in_idle_s & if_req_i & (~dm_req_i | if_force_s);
  assign dm_win_s  = in_idle_s & dm_req_i & ~if_win_s;

  arb_starve_cnt #(
    .MAX_IF_WAIT (MAX_IF_WAIT)
  ) u_starve_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .dm_win_i   (dm_win_s & if_req_i),
    .if_win_i   (if_win_s),
    .if_force_o (if_force_s)
  );

  // Sequencer: arbitrate and capture in IDLE, hold request until grant, wait for the response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OWN_DM;
      kill_q  <= 1'b0;
      addr_q  <= {AW{1'b0}};
      we_q    <= 1'b0;
      be_q    <= {BW{1'b0}};
      wdata_q <= {DW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (if_win_s) begin
            owner_q <= OWN_IF;
            addr_q  <= if_addr_i;
            we_q    <= 1'b0;
            be_q    <= {BW{1'b1}};
            wdata_q <= {DW{1'b0}};
            state_q <= REQ;
          end else if (dm_win_s) begin
            owner_q <= OWN_DM;
            addr_q  <= dm_addr_i;
            we_q    <= dm_we_i;
            be_q    <= dm_be_i;
            wdata_q <= dm_wdata_i;
            state_q <= REQ;
          end
        end
        REQ: begin
          if ((owner_q == OWN_IF) && if_kill_i) begin
            kill_q <= 1'b1;
          end
          if (mem_gnt_i) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if ((owner_q == OWN_IF) && if_kill_i) begin
            kill_q <= 1'b1;
          end
          // The response completes the transaction; a pending kill is consumed here
          if (mem_rvalid_i) begin
            kill_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          kill_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Responses only count in RESP; a reset cycle never produces a pulse
  assign resp_done_s = (state_q == RESP) & mem_rvalid_i & ~rst_i;

  // A kill in the response cycle itself must also suppress the pulse
  assign if_rvalid_o = resp_done_s & (owner_q == OWN_IF) & ~kill_q & ~if_kill_i;
  assign dm_rvalid_o = resp_done_s & (owner_q == OWN_DM);
  assign if_rdata_o  = mem_rdata_i;
  assign dm_rdata_o  = mem_rdata_i;

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign stall_f_o   = if_req_i & ~if_rvalid_o;
  assign stall_m_o   = dm_req_i & ~dm_rvalid_o;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
module tb_imem_dmem_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_kill_i;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        stall_f_o;
  logic        stall_m_o;

  int vec_cnt;
  int err_cnt;

  imem_dmem_arbiter #(
    .AW          (32),
    .DW          (32),
    .MAX_IF_WAIT (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_kill_i    (if_kill_i),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .dm_req_i     (dm_req_i),
    .dm_we_i      (dm_we_i),
    .dm_be_i      (dm_be_i),
    .dm_addr_i    (dm_addr_i),
    .dm_wdata_i   (dm_wdata_i),
    .dm_rvalid_o  (dm_rvalid_o),
    .dm_rdata_o   (dm_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .stall_f_o    (stall_f_o),
    .stall_m_o    (stall_m_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later
  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    #1;
    vec_cnt++; if (mem_req_o !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_req: got %0b want 0", mem_req_o); end
    vec_cnt++; if (mem_we_o !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_we: got %0b want 0", mem_we_o); end
    vec_cnt++; if (mem_be_o !== 4'h0) begin err_cnt++; $display("FAIL reset_mem_be: got %h want 0", mem_be_o); end
    vec_cnt++; if (mem_addr_o !== 32'h0) begin err_cnt++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr_o); end
    vec_cnt++; if (mem_wdata_o !== 32'h0) begin err_cnt++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata_o); end
    vec_cnt++; if ({if_rvalid_o, dm_rvalid_o} !== 2'b00) begin err_cnt++; $display("FAIL reset_rvalid: got %b want 00", {if_rvalid_o, dm_rvalid_o}); end
    vec_cnt++; if ({stall_f_o, stall_m_o} !== 2'b00) begin err_cnt++; $display("FAIL reset_stall: got %b want 00", {stall_f_o, stall_m_o}); end
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_lone_fetch();
    step();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    #1;
    vec_cnt++; if (stall_f_o !== 1'b1) begin err_cnt++; $display("FAIL lone_stall_n: got %0b want 1", stall_f_o); end
    vec_cnt++; if (mem_req_o !== 1'b0) begin err_cnt++; $display("FAIL lone_req_n: got %0b want 0", mem_req_o); end
    step();
    mem_gnt_i = 1'b1;
    #1;
    vec_cnt++; if (mem_req_o !== 1'b1) begin err_cnt++; $display("FAIL lone_req_n1: got %0b want 1", mem_req_o); end
    vec_cnt++; if (mem_addr_o !== 32'h0000_0100) begin err_cnt++; $display("FAIL lone_addr: got %h want 00000100", mem_addr_o); end
    vec_cnt++; if ({mem_we_o, mem_be_o} !== 5'b0_1111) begin err_cnt++; $display("FAIL lone_we_be: got %b want 01111", {mem_we_o, mem_be_o}); end
    vec_cnt++; if (stall_f_o !== 1'b1) begin err_cnt++; $display("FAIL lone_stall_n1: got %0b want 1", stall_f_o); end
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    vec_cnt++; if (if_rvalid_o !== 1'b1) begin err_cnt++; $display("FAIL lone_rvalid: got %0b want 1", if_rvalid_o); end
    vec_cnt++; if (if_rdata_o !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL lone_rdata: got %h want deadbeef", if_rdata_o); end
    vec_cnt++; if (stall_f_o !== 1'b0) begin err_cnt++; $display("FAIL lone_stall_n2: got %0b want 0", stall_f_o); end
    vec_cnt++; if ({mem_req_o, dm_rvalid_o} !== 2'b00) begin err_cnt++; $display("FAIL lone_req_dmv_n2: got %b want 00", {mem_req_o, dm_rvalid_o}); end
    step();
    mem_rvalid_i = 1'b0; if_req_i = 1'b0;
    #1;
    vec_cnt++; if (if_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL lone_pulse_end: got %0b want 0", if_rvalid_o); end
  endtask

  task automatic test_simultaneous();
    step();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0300;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h0000_2000; dm_wdata_i = 32'h0;
    #1;
    vec_cnt++; if ({stall_f_o, stall_m_o} !== 2'b11) begin err_cnt++; $display("FAIL sim_stall_arb: got %b want 11", {stall_f_o, stall_m_o}); end
    step();
    mem_gnt_i = 1'b1;
    #1;
    vec_cnt++; if (mem_req_o !== 1'b1) begin err_cnt++; $display("FAIL sim_dm_req: got %0b want 1", mem_req_o); end
    vec_cnt++; if (mem_addr_o !== 32'h0000_2000) begin err_cnt++; $display("FAIL sim_dm_addr: got %h want 00002000", mem_addr_o); end
    vec_cnt++; if (mem_we_o !== 1'b0) begin err_cnt++; $display("FAIL sim_dm_we: got %0b want 0", mem_we_o); end
    vec_cnt++; if (stall_f_o !== 1'b1) begin err_cnt++; $display("FAIL sim_stall_f_req: got %0b want 1", stall_f_o); end
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    #1;
    vec_cnt++; if ({dm_rvalid_o, if_rvalid_o} !== 2'b10) begin err_cnt++; $display("FAIL sim_dm_resp: got %b want 10", {dm_rvalid_o, if_rvalid_o}); end
    vec_cnt++; if (dm_rdata_o !== 32'h1111_2222) begin err_cnt++; $display("FAIL sim_dm_rdata: got %h want 11112222", dm_rdata_o); end
    vec_cnt++; if ({stall_f_o, stall_m_o} !== 2'b10) begin err_cnt++; $display("FAIL sim_stall_resp: got %b want 10", {stall_f_o, stall_m_o}); end
    step();
    mem_rvalid_i = 1'b0; dm_req_i = 1'b0;
    #1;
    vec_cnt++; if (mem_req_o !== 1'b0) begin err_cnt++; $display("FAIL sim_no_b2b: got %0b want 0", mem_req_o); end
    step();
    mem_gnt_i = 1'b1;
    #1;
    vec_cnt++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0000_0300}) begin err_cnt++; $display("FAIL sim_if_issue: got %b/%h want 1/00000300", mem_req_o, mem_addr_o); end
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3333_4444;
    #1;
    vec_cnt++; if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h3333_4444}) begin err_cnt++; $display("FAIL sim_if_resp: got %b/%h want 1/33334444", if_rvalid_o, if_rdata_o); end
    step();
    mem_rvalid_i = 1'b0; if_req_i = 1'b0;
  endtask

  task automatic test_starvation();
    logic [3:0] exp_if_win;
    exp_if_win = 4'b0100;  // rounds 0..3: DM, DM, IF, DM (count restarted after the IF win)
    step();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0400;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h0000_0500;
    for (int k = 0; k < 4; k++) begin
      #1;
      vec_cnt++; if (mem_req_o !== 1'b0) begin err_cnt++; $display("FAIL starve_idle_%0d: got %0b want 0", k, mem_req_o); end
      step();
      mem_gnt_i = 1'b1;
      #1;
      vec_cnt++; if (mem_addr_o !== (exp_if_win[k] ? 32'h0000_0400 : 32'h0000_0500)) begin err_cnt++; $display("FAIL starve_addr_%0d: got %h want %h", k, mem_addr_o, (exp_if_win[k] ? 32'h0000_0400 : 32'h0000_0500)); end
      step();
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA000_0000 + k;
      #1;
      vec_cnt++; if ({if_rvalid_o, dm_rvalid_o} !== {exp_if_win[k], ~exp_if_win[k]}) begin err_cnt++; $display("FAIL starve_resp_%0d: got %b want %b", k, {if_rvalid_o, dm_rvalid_o}, {exp_if_win[k], ~exp_if_win[k]}); end
      step();
      mem_rvalid_i = 1'b0;
      if (k == 3) begin
        if_req_i = 1'b0; dm_req_i = 1'b0;
      end
    end
  endtask

  task automatic test_kill();
    step();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    step();
    mem_gnt_i = 1'b1;
    #1;
    vec_cnt++; if (mem_req_o !== 1'b1) begin err_cnt++; $display("FAIL kill_req: got %0b want 1", mem_req_o); end
    step();
    mem_gnt_i = 1'b0; if_kill_i = 1'b1;
    #1;
    vec_cnt++; if (if_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL kill_pulse_wait: got %0b want 0", if_rvalid_o); end
    step();
    if_kill_i = 1'b0; if_addr_i = 32'h0000_0180; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    #1;
    vec_cnt++; if (if_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL kill_suppress: got %0b want 0", if_rvalid_o); end
    vec_cnt++; if (stall_f_o !== 1'b1) begin err_cnt++; $display("FAIL kill_stall: got %0b want 1", stall_f_o); end
    step();
    mem_rvalid_i = 1'b0;
    #1;
    vec_cnt++; if (mem_req_o !== 1'b0) begin err_cnt++; $display("FAIL kill_idle: got %0b want 0", mem_req_o); end
    step();
    mem_gnt_i = 1'b1;
    #1;
    vec_cnt++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0000_0180}) begin err_cnt++; $display("FAIL kill_new_addr: got %b/%h want 1/00000180", mem_req_o, mem_addr_o); end
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0C0F_FEE0;
    #1;
    vec_cnt++; if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h0C0F_FEE0}) begin err_cnt++; $display("FAIL kill_new_resp: got %b/%h want 1/0c0ffee0", if_rvalid_o, if_rdata_o); end
    // Kill while IDLE is ignored
    step();
    mem_rvalid_i = 1'b0; if_addr_i = 32'h0000_0200; if_kill_i = 1'b1;
    step();
    if_kill_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    vec_cnt++; if (mem_addr_o !== 32'h0000_0200) begin err_cnt++; $display("FAIL kill_idle_addr: got %h want 00000200", mem_addr_o); end
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
    #1;
    vec_cnt++; if (if_rvalid_o !== 1'b1) begin err_cnt++; $display("FAIL kill_idle_noeffect: got %0b want 1", if_rvalid_o); end
    // Kill in the same cycle as the response
    step();
    mem_rvalid_i = 1'b0; if_addr_i = 32'h0000_0240;
    step();
    mem_gnt_i = 1'b1;
    #1;
    vec_cnt++; if (mem_addr_o !== 32'h0000_0240) begin err_cnt++; $display("FAIL kill_same_addr: got %h want 00000240", mem_addr_o); end
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; if_kill_i = 1'b1;
    #1;
    vec_cnt++; if (if_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL kill_same_cycle: got %0b want 0", if_rvalid_o); end
    step();
    mem_rvalid_i = 1'b0; if_kill_i = 1'b0; if_req_i = 1'b0;
    #1;
    vec_cnt++; if (mem_req_o !== 1'b0) begin err_cnt++; $display("FAIL kill_back_idle: got %0b want 0", mem_req_o); end
  endtask

  task automatic test_store_stall();
    step();
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'b0011; dm_addr_i = 32'h0000_3000; dm_wdata_i = 32'h1234_ABCD;
    #1;
    vec_cnt++; if (stall_m_o !== 1'b1) begin err_cnt++; $display("FAIL st_stall_arb: got %0b want 1", stall_m_o); end
    for (int i = 0; i < 4; i++) begin
      step();
      mem_gnt_i    = (i == 3);
      mem_rvalid_i = (i == 1);  // stray response while waiting for grant
      #1;
      vec_cnt++; if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b1_1_0011) begin err_cnt++; $display("FAIL st_ctrl_%0d: got %b want 110011", i, {mem_req_o, mem_we_o, mem_be_o}); end
      vec_cnt++; if ({mem_addr_o, mem_wdata_o} !== {32'h0000_3000, 32'h1234_ABCD}) begin err_cnt++; $display("FAIL st_payload_%0d: got %h/%h want 00003000/1234abcd", i, mem_addr_o, mem_wdata_o); end
      vec_cnt++; if ({dm_rvalid_o, stall_m_o} !== 2'b01) begin err_cnt++; $display("FAIL st_wait_%0d: got %b want 01", i, {dm_rvalid_o, stall_m_o}); end
    end
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    #1;
    vec_cnt++; if ({dm_rvalid_o, stall_m_o, mem_req_o} !== 3'b100) begin err_cnt++; $display("FAIL st_ack: got %b want 100", {dm_rvalid_o, stall_m_o, mem_req_o}); end
    step();
    mem_rvalid_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    #1;
    vec_cnt++; if (dm_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL st_pulse_end: got %0b want 0", dm_rvalid_o); end
  endtask

  task automatic test_reset_midop();
    step();
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h0000_4000;
    step();
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0; rst_i = 1'b1; dm_req_i = 1'b0;
    #1;
    vec_cnt++; if (dm_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_rvalid: got %0b want 0", dm_rvalid_o); end
    step();
    rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_8888;
    #1;
    vec_cnt++; if ({if_rvalid_o, dm_rvalid_o} !== 2'b00) begin err_cnt++; $display("FAIL rst_stale_rvalid: got %b want 00", {if_rvalid_o, dm_rvalid_o}); end
    vec_cnt++; if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b0) begin err_cnt++; $display("FAIL rst_mem_ctrl: got %b want 000000", {mem_req_o, mem_we_o, mem_be_o}); end
    vec_cnt++; if ({mem_addr_o, mem_wdata_o} !== 64'h0) begin err_cnt++; $display("FAIL rst_mem_payload: got %h/%h want 0/0", mem_addr_o, mem_wdata_o); end
    step();
    mem_rvalid_i = 1'b0;
    #1;
    vec_cnt++; if ({mem_req_o, if_rvalid_o, dm_rvalid_o} !== 3'b000) begin err_cnt++; $display("FAIL rst_after_idle: got %b want 000", {mem_req_o, if_rvalid_o, dm_rvalid_o}); end
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0;
    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'h0; if_kill_i = 1'b0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = 4'h0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_starvation();
    test_kill();
    test_store_stall();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
